mem_access_unit: RTL and testbench

//   Load/store front end between the EX/MEM pipeline register and DataMemory. Maps LW/LH/LHU/LB/LBU/SW/SH/SB

---
 rtl/mem_access_unit_pkg.sv | 51 +++++
 rtl/mem_access_unit_if.sv | 11 +
 rtl/mem_access_unit_load_extract.sv | 32 +++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 tb/tb_mem_access_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store front end: memory op codes, FSM
// states and the alignment / lane-merge helpers.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } memOp_e;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } rmwState_e;

    // Word ops need a 4-byte aligned address, halfword ops a 2-byte one.
    function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        case (op)
            OP_LW, OP_SW:         bad = (off != 2'b00);
            OP_LH, OP_LHU, OP_SH: bad = off[0];
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Replace one big-endian lane of 'word' with the low bits of 'data'.
    function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] op, input logic [15:0] data);
        logic [31:0] merged;
        merged = word;
        if (op == OP_SH) begin
            if (off[1] == 1'b0) merged[31:16] = data;
            else                merged[15:0]  = data;
        end else begin
            case (off)
                2'b00:   merged[31:24] = data[7:0];
                2'b01:   merged[23:16] = data[7:0];
                2'b10:   merged[15:8]  = data[7:0];
                default: merged[7:0]   = data[7:0];
            endcase
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide DataMemory bus: the access unit is master, the memory is slave.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] MemAddress;
    logic [31:0]       MemWriteData;
    logic              MemWrite;
    logic              MemRead;
    logic [31:0]       MemReadData;

    modport master (output MemAddress, MemWriteData, MemWrite, MemRead, input MemReadData);
    modport slave  (input MemAddress, MemWriteData, MemWrite, MemRead, output MemReadData);
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Selects the addressed big-endian lane of a memory word and extends it
// to 32 bits according to the load op. Purely combinational.
module mem_access_unit_load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] loadData
);
    logic [7:0]  byteLane_s;
    logic [15:0] halfLane_s;

    // Lane select and sign/zero extension.
    always_comb begin
        case (offset)
            2'b00:   byteLane_s = word[31:24];
            2'b01:   byteLane_s = word[23:16];
            2'b10:   byteLane_s = word[15:8];
            default: byteLane_s = word[7:0];
        endcase
        halfLane_s = offset[1] ? word[15:0] : word[31:16];
        case (op)
            OP_LW:   loadData = word;
            OP_LH:   loadData = {{16{halfLane_s[15]}}, halfLane_s};
            OP_LHU:  loadData = {16'h0000, halfLane_s};
            OP_LB:   loadData = {{24{byteLane_s[7]}}, byteLane_s};
            OP_LBU:  loadData = {24'h000000, byteLane_s};
            default: loadData = 32'h0000_0000;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between EX/MEM and DataMemory. Loads and SW complete
// in one cycle; SH/SB run a read-modify-write that stalls the pipe one cycle.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int STALLCNT_W = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MemAccess,
    input  logic [2:0]            MemOp,
    input  logic [ADDR_W-1:0]     Address,
    input  logic [31:0]           StoreData,
    mem_access_unit_if.master     memBus,
    output logic [31:0]           LoadData,
    output logic                  Stall,
    output logic                  AddrError,
    output logic [STALLCNT_W-1:0] StallCount
);
    localparam logic [STALLCNT_W-1:0] CNT_ONE = {{(STALLCNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALLCNT_W-1:0] CNT_MAX = {STALLCNT_W{1'b1}};

    rmwState_e             state_r;
    logic [31:0]           mergeWord_r;
    logic [2:0]            heldOp_r;
    logic [ADDR_W-1:0]     heldAddr_r;
    logic [15:0]           heldData_r;
    logic                  addrError_r;
    logic [STALLCNT_W-1:0] stallCount_r;

    logic                  misaligned_s;
    logic [31:0]           extracted_s;
    logic [ADDR_W-1:0]     memAddress_s;
    logic [31:0]           memWriteData_s;
    logic                  memWrite_s;
    logic                  memRead_s;
    logic [31:0]           loadData_s;
    logic                  stall_s;

    mem_access_unit_load_extract u_loadExtract (
        .word     (memBus.MemReadData),
        .offset   (Address[1:0]),
        .op       (MemOp),
        .loadData (extracted_s)
    );

    // Decode the current request (or the pending RMW write) into bus controls.
    always_comb begin
        memAddress_s   = '0;
        memWriteData_s = 32'h0000_0000;
        memWrite_s     = 1'b0;
        memRead_s      = 1'b0;
        loadData_s     = 32'h0000_0000;
        stall_s        = 1'b0;
        misaligned_s   = MemAccess && isMisaligned(MemOp, Address[1:0]);
        if (state_r == RMW_WR) begin
            // Second half of SH/SB: write the merged word, request inputs ignored.
            memAddress_s   = {heldAddr_r[ADDR_W-1:2], 2'b00};
            memWriteData_s = mergeLane(mergeWord_r, heldAddr_r[1:0], heldOp_r, heldData_r);
            memWrite_s     = 1'b1;
        end else if (MemAccess && !misaligned_s) begin
            memAddress_s = {Address[ADDR_W-1:2], 2'b00};
            case (MemOp)
                OP_SW: begin
                    memWrite_s     = 1'b1;
                    memWriteData_s = StoreData;
                end
                OP_SH, OP_SB: begin
                    memRead_s = 1'b1;
                    stall_s   = 1'b1;
                end
                default: begin
                    memRead_s  = 1'b1;
                    loadData_s = extracted_s;
                end
            endcase
        end else begin
            memAddress_s = '0;
        end
    end

    // FSM plus the RMW capture registers, error pulse and stall counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= IDLE;
            mergeWord_r  <= 32'h0000_0000;
            heldOp_r     <= 3'd0;
            heldAddr_r   <= '0;
            heldData_r   <= 16'h0000;
            addrError_r  <= 1'b0;
            stallCount_r <= '0;
        end else begin
            addrError_r <= (state_r == IDLE) && misaligned_s;
            if (stall_s && (stallCount_r != CNT_MAX)) begin
                stallCount_r <= stallCount_r + CNT_ONE;
            end
            case (state_r)
                IDLE: begin
                    if (stall_s) begin
                        mergeWord_r <= memBus.MemReadData;
                        heldOp_r    <= MemOp;
                        heldAddr_r  <= Address;
                        heldData_r  <= StoreData[15:0];
                        state_r     <= RMW_WR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RMW_WR:  state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign memBus.MemAddress   = memAddress_s;
    assign memBus.MemWriteData = memWriteData_s;
    assign memBus.MemWrite     = memWrite_s;
    assign memBus.MemRead      = memRead_s;
    assign LoadData            = loadData_s;
    assign Stall               = stall_s;
    assign AddrError           = addrError_r;
    assign StallCount          = stallCount_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural DataMemory.
// The stimulus process pushes expected bus events; the monitor pops and
// compares them whenever the DUT shows a load result, write, stall or error.
// StallCount is narrowed to 10 bits so saturation is reachable quickly.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int SCW    = 10;
    localparam int NWORDS = 16;

    localparam int K_AERR  = 0;
    localparam int K_STALL = 1;
    localparam int K_LOAD  = 2;
    localparam int K_WRITE = 3;
    localparam int P_IDLE  = 4;
    localparam int P_CNT   = 5;
    localparam int P_MEM   = 6;
    localparam int P_NOWR  = 7;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } item_t;

    logic           Clk       = 1'b0;
    logic           Reset     = 1'b0;
    logic           MemAccess = 1'b0;
    logic [2:0]     MemOp     = 3'd0;
    logic [31:0]    Address   = 32'd0;
    logic [31:0]    StoreData = 32'd0;
    logic [31:0]    LoadData;
    logic           Stall;
    logic           AddrError;
    logic [SCW-1:0] StallCount;

    logic           loadReq = 1'b0;
    logic [3:0]     loadIdx = 4'd0;
    logic [31:0]    loadVal = 32'd0;
    logic [31:0]    dmem   [0:NWORDS-1];
    logic [31:0]    refMem [0:NWORDS-1];

    item_t expQ[$];
    item_t probeQ[$];
    int    nCompared = 0;
    int    nMismatch = 0;
    int    stallModel = 0;
    bit    finishReq = 1'b0;

    mem_access_unit_if #(.ADDR_W(32)) memBus ();

    mem_access_unit #(.ADDR_W(32), .STALLCNT_W(SCW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MemAccess  (MemAccess),
        .MemOp      (MemOp),
        .Address    (Address),
        .StoreData  (StoreData),
        .memBus     (memBus),
        .LoadData   (LoadData),
        .Stall      (Stall),
        .AddrError  (AddrError),
        .StallCount (StallCount)
    );

    always #5 Clk = ~Clk;

    // DataMemory: combinational read, write on rising clock, preload port.
    assign memBus.MemReadData = dmem[memBus.MemAddress[5:2]];
    always @(posedge Clk) begin
        if (loadReq) dmem[loadIdx] <= loadVal;
        else if (memBus.MemWrite) dmem[memBus.MemAddress[5:2]] <= memBus.MemWriteData;
    end

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int opSize(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd5) return 4;
        if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
        return 1;
    endfunction

    function automatic bit opSigned(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd3);
    endfunction

    function automatic bit opIsLoad(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    // Value of the 'size'-byte field starting at byte 'off' (byte 0 = MSB).
    function automatic logic [31:0] refLoad(input logic [31:0] w, input int off, input logic [2:0] op);
        longint one, sh, mask, v;
        int     size;
        size = opSize(op);
        one  = 1;
        sh   = 8 * (4 - size - off);
        mask = (one << (8 * size)) - one;
        v    = (longint'(w) >> sh) & mask;
        if (opSigned(op) && v >= (one << (8 * size - 1))) v = v - (one << (8 * size));
        return v[31:0];
    endfunction

    function automatic logic [31:0] refStore(input logic [31:0] w, input int off,
                                             input logic [2:0] op, input logic [31:0] data);
        longint one, sh, mask, v;
        int     size;
        size = opSize(op);
        one  = 1;
        sh   = 8 * (4 - size - off);
        mask = (one << (8 * size)) - one;
        v    = (longint'(w) & ~(mask << sh)) | ((longint'(data) & mask) << sh);
        return v[31:0];
    endfunction

    function automatic string kindName(input int k);
        case (k)
            K_AERR:  return "addr_error";
            K_STALL: return "stall";
            K_LOAD:  return "load_data";
            K_WRITE: return "mem_write";
            default: return "other";
        endcase
    endfunction

    // ---------------- monitor / checker ----------------
    task automatic expectOut(input int kind, input logic [31:0] a, input logic [31:0] d);
        item_t e;
        nCompared++;
        if (expQ.size() == 0) begin
            nMismatch++;
            $display("FAIL unexpected_%s: got a=%h d=%h, required no output", kindName(kind), a, d);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.a !== a || e.d !== d) begin
                nMismatch++;
                $display("FAIL %s: got %s a=%h d=%h, required %s a=%h d=%h",
                         kindName(e.kind), kindName(kind), a, d, kindName(e.kind), e.a, e.d);
            end
        end
    endtask

    task automatic doProbe(input item_t p);
        nCompared++;
        case (p.kind)
            P_IDLE: begin
                if (memBus.MemWrite !== 1'b0 || memBus.MemRead !== 1'b0 || Stall !== 1'b0 ||
                    LoadData !== 32'd0 || memBus.MemAddress !== 32'd0 ||
                    memBus.MemWriteData !== 32'd0 || AddrError !== 1'b0) begin
                    nMismatch++;
                    $display("FAIL idle_outputs: got we=%b re=%b st=%b ld=%h ad=%h wd=%h ae=%b, required all zero",
                             memBus.MemWrite, memBus.MemRead, Stall, LoadData,
                             memBus.MemAddress, memBus.MemWriteData, AddrError);
                end
            end
            P_CNT: begin
                if (StallCount !== p.d[SCW-1:0]) begin
                    nMismatch++;
                    $display("FAIL stall_count: got %0d, required %0d", StallCount, p.d[SCW-1:0]);
                end
            end
            P_MEM: begin
                if (dmem[p.a[5:2]] !== p.d) begin
                    nMismatch++;
                    $display("FAIL mem_word[%h]: got %h, required %h", p.a, dmem[p.a[5:2]], p.d);
                end
            end
            default: begin
                if (memBus.MemWrite !== 1'b0) begin
                    nMismatch++;
                    $display("FAIL write_in_reset: got MemWrite=%b, required 0", memBus.MemWrite);
                end
            end
        endcase
    endtask

    initial begin : monitor
        forever begin
            @(negedge Clk);
            while (probeQ.size() > 0) begin
                item_t p;
                p = probeQ.pop_front();
                doProbe(p);
            end
            if (AddrError)                   expectOut(K_AERR, 32'd0, 32'd0);
            if (Stall)                       expectOut(K_STALL, 32'd0, 32'd0);
            if (memBus.MemRead && !Stall)    expectOut(K_LOAD, 32'd0, LoadData);
            if (memBus.MemWrite)             expectOut(K_WRITE, memBus.MemAddress, memBus.MemWriteData);
            if (finishReq) begin
                nCompared++;
                if (expQ.size() != 0) begin
                    nMismatch++;
                    $display("FAIL missing_outputs: got %0d events outstanding, required 0", expQ.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
                $finish;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    function automatic item_t mk(input int kind, input logic [31:0] a, input logic [31:0] d);
        item_t it;
        it.kind = kind;
        it.a    = a;
        it.d    = d;
        return it;
    endfunction

    task automatic probe(input int kind, input logic [31:0] a, input logic [31:0] d);
        probeQ.push_back(mk(kind, a, d));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1;
            MemAccess = 1'b0;
            MemOp     = 3'($urandom);
            Address   = $urandom;
            StoreData = $urandom;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        int          idx, off;
        logic [31:0] w, nw;
        @(posedge Clk); #1;
        MemAccess = 1'b1;
        MemOp     = op;
        Address   = addr;
        StoreData = data;
        idx = int'(addr[5:2]);
        off = int'(addr[1:0]);
        w   = refMem[idx];
        if ((off % opSize(op)) != 0) begin
            expQ.push_back(mk(K_AERR, 32'd0, 32'd0));
        end else if (opIsLoad(op)) begin
            expQ.push_back(mk(K_LOAD, 32'd0, refLoad(w, off, op)));
        end else begin
            nw = refStore(w, off, op, data);
            if (opSize(op) != 4) begin
                expQ.push_back(mk(K_STALL, 32'd0, 32'd0));
                if (stallModel < (1 << SCW) - 1) stallModel++;
            end
            expQ.push_back(mk(K_WRITE, {addr[31:2], 2'b00}, nw));
            refMem[idx] = nw;
            if (opSize(op) != 4) begin
                @(posedge Clk); #1;   // pipeline re-presents the same instruction
            end
        end
    endtask

    initial begin : stimulus
        logic [2:0]  op;
        logic [31:0] addr;
        // preload while reset is held
        for (int i = 0; i < NWORDS; i++) begin
            @(posedge Clk); #1;
            loadReq   = 1'b1;
            loadIdx   = 4'(i);
            loadVal   = (i == 4) ? 32'h1122_3344 : $urandom;
            refMem[i] = loadVal;
        end
        @(posedge Clk); #1;
        loadReq = 1'b0;
        probe(P_IDLE, 32'd0, 32'd0);
        probe(P_CNT, 32'd0, 32'd0);
        idle(1);
        Reset = 1'b1;
        idle(1);
        probe(P_IDLE, 32'd0, 32'd0);

        // directed loads
        issue(OP_LW,  32'h10, 32'd0);
        issue(OP_LB,  32'h11, 32'd0);
        issue(OP_LHU, 32'h12, 32'd0);
        issue(OP_LH,  32'h12, 32'd0);
        // RMW byte store and readback
        issue(OP_SB,  32'h12, 32'h0000_00AB);
        issue(OP_LW,  32'h10, 32'd0);
        idle(1);
        probe(P_CNT, 32'd0, 32'(stallModel));
        probe(P_MEM, 32'h10, refMem[4]);
        // restore, then back-to-back SH + SB
        issue(OP_SW,  32'h10, 32'h1122_3344);
        issue(OP_SH,  32'h10, 32'h0000_BEEF);
        issue(OP_SB,  32'h13, 32'h0000_005A);
        idle(1);
        probe(P_MEM, 32'h10, refMem[4]);
        probe(P_CNT, 32'd0, 32'(stallModel));
        // negative byte
        issue(OP_SW,  32'h10, 32'h80FF_7F01);
        issue(OP_LB,  32'h10, 32'd0);
        issue(OP_LBU, 32'h10, 32'd0);
        issue(OP_LH,  32'h12, 32'd0);
        // misaligned accesses
        issue(OP_LW,  32'h11, 32'd0);
        issue(OP_SH,  32'h13, 32'h0000_1234);
        idle(2);
        probe(P_MEM, 32'h10, refMem[4]);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op   = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) < 7) addr = addr & ~32'(opSize(op) - 1);
            issue(op, addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(2);
        probe(P_CNT, 32'd0, 32'(stallModel));
        for (int i = 0; i < NWORDS; i++) probe(P_MEM, 32'(i * 4), refMem[i]);
        idle(1);

        // reset in the middle of a read-modify-write
        @(posedge Clk); #1;
        MemAccess = 1'b1;
        MemOp     = OP_SB;
        Address   = 32'h10;
        StoreData = 32'h0000_00C3;
        expQ.push_back(mk(K_STALL, 32'd0, 32'd0));
        @(posedge Clk); #1;
        Reset     = 1'b0;
        MemAccess = 1'b0;
        probe(P_NOWR, 32'd0, 32'd0);
        @(posedge Clk); #1;
        Reset      = 1'b1;
        stallModel = 0;
        probe(P_CNT, 32'd0, 32'd0);
        probe(P_MEM, 32'h10, refMem[4]);
        issue(OP_LW, 32'h10, 32'd0);
        issue(OP_SW, 32'h14, 32'hCAFE_F00D);
        idle(1);
        probe(P_CNT, 32'd0, 32'd0);

        // saturate the stall counter
        for (int n = 0; n < (1 << SCW) + 6; n++) begin
            issue(OP_SB, 32'($urandom_range(0, 63)), $urandom);
        end
        idle(1);
        probe(P_CNT, 32'd0, 32'(stallModel));
        idle(2);
        finishReq = 1'b1;
    end

endmodule
